fmap_pingpong_bram: RTL

//   Parametrised ping-pong feature-map buffer between CNN engine stages (e.g. conv -> max-pool -> next conv).
//   Two BRAM banks: the producer fills one while the consumer drains the other, with per-bank full/empty tracking and a done-pulse swap handshake.

---
 rtl/fmap_pingpong_bram.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fmap_pingpong_bram.sv
// Ping-pong feature-map buffer: two BRAM banks, one filled by the producer
// while the consumer drains the other. Banks move EMPTY -> FILLING -> FULL ->
// EMPTY, swapped by one-cycle wr_done / rd_done pulses. Illegal requests are
// dropped and latch a sticky err flag.
module fmap_pingpong_bram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] wr_we,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_done,
  output logic                wr_ready,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_done,
  output logic                rd_avail,
  output logic                wr_bank,
  output logic                rd_bank,
  output logic                err
);

  localparam int NB        = DATA_W / 8;
  // Each bank occupies a power-of-two slot so {bank, addr} forms the RAM index.
  localparam int MEM_WORDS = 2 * (1 << ADDR_W);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0] bank_st_q [2];
  logic [1:0] bank_st_d [2];
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic       err_q, err_d;

  logic wr_ready_c, rd_avail_c;
  logic wr_addr_ok, rd_addr_ok;
  logic wr_acc, rd_acc;
  logic wr_swap, rd_swap;
  logic err_evt;

  logic [DATA_W-1:0] ram [MEM_WORDS];
  logic              rd_v1_q;
  logic [DATA_W-1:0] rd_d1_q;

  // Bank state register, bank pointers and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0] <= ST_EMPTY;
      bank_st_q[1] <= ST_EMPTY;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      err_q        <= err_d;
    end
  end

  // Next bank states: apply swaps, then claim the new write bank if it is free.
  always_comb begin
    bank_st_d[0] = bank_st_q[0];
    bank_st_d[1] = bank_st_q[1];
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    err_d        = err_q | err_evt;
    if (wr_swap) begin
      bank_st_d[wr_bank_q] = ST_FULL;
      wr_bank_d            = ~wr_bank_q;
    end
    if (rd_swap) begin
      bank_st_d[rd_bank_q] = ST_EMPTY;
      rd_bank_d            = ~rd_bank_q;
    end
    // A bank released this same cycle is reclaimed at once: zero-bubble swap.
    if (bank_st_d[wr_bank_d] == ST_EMPTY) begin
      bank_st_d[wr_bank_d] = ST_FILL;
    end
  end

  // Handshake outputs, request qualification and error detection.
  always_comb begin
    wr_ready_c = (bank_st_q[wr_bank_q] == ST_FILL);
    rd_avail_c = (bank_st_q[rd_bank_q] == ST_FULL);
    wr_addr_ok = (32'(wr_addr) < 32'(DEPTH));
    rd_addr_ok = (32'(rd_addr) < 32'(DEPTH));
    wr_acc     = !rst && wr_en && wr_ready_c && wr_addr_ok;
    rd_acc     = !rst && rd_en && rd_avail_c && rd_addr_ok;
    wr_swap    = wr_done && wr_ready_c;
    rd_swap    = rd_done && rd_avail_c;
    err_evt    = (wr_en && (!wr_ready_c || !wr_addr_ok)) ||
                 (rd_en && (!rd_avail_c || !rd_addr_ok)) ||
                 (wr_done && !wr_ready_c) ||
                 (rd_done && !rd_avail_c);
    wr_ready   = wr_ready_c;
    rd_avail   = rd_avail_c;
    wr_bank    = wr_bank_q;
    rd_bank    = rd_bank_q;
    err        = err_q;
  end

  // Producer port: byte-masked write into the current write bank.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_we[b]) begin
          ram[{wr_bank_q, wr_addr}][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Consumer port: registered BRAM read; data holds between accepted reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_q <= 1'b0;
      rd_d1_q <= '0;
    end else begin
      rd_v1_q <= rd_acc;
      if (rd_acc) begin
        rd_d1_q <= ram[{rd_bank_q, rd_addr}];
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              rd_v2_q;
      logic [DATA_W-1:0] rd_d2_q;

      // Optional output register stage for the two-cycle latency build.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_v2_q <= 1'b0;
          rd_d2_q <= '0;
        end else begin
          rd_v2_q <= rd_v1_q;
          if (rd_v1_q) begin
            rd_d2_q <= rd_d1_q;
          end
        end
      end

      assign rd_valid = rd_v2_q;
      assign rd_data  = rd_d2_q;
    end else begin : g_lat1
      assign rd_valid = rd_v1_q;
      assign rd_data  = rd_d1_q;
    end
  endgenerate

endmodule
